aes_key_expander: RTL and testbench

Iterative AES-128 key schedule that sits directly upstream of the encryption datapath. It accepts one 128-bit cipher key through a valid/ready handshake and derives round keys 1–10 at one per clock, storing all 11 keys internally. The encryption core reads the keys by round index, so it no longer computes round keys inline.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_key_expander_if.sv | 25 ++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_key_expander.sv | 120 ++++++++++++
 tb/tb_aes_key_expander.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round constants, FSM state type and
// small word helpers used by the key schedule and the cipher datapath.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned AES_KW = 128;

  typedef logic [31:0]       word_t;
  typedef logic [AES_KW-1:0] block_t;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } fsm_t;

  // Round constants; entry 0 is unused so the array is indexed by round number.
  localparam logic [7:0] RCON [AES_NR+1] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Cyclic left rotation of a word by one byte.
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant lookup for a 4-bit round index; out-of-range gives 0.
  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 1; i <= AES_NR; i++) begin
      if (rnd == 4'(i)) r = RCON[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-load handshake and round-key read port of the AES key expander.
interface aes_key_expander_if;
  import aes_pkg::*;

  logic       key_valid;
  block_t     key_in;
  logic       key_ready;
  logic [3:0] rk_idx;
  block_t     rk_out;
  logic       keys_valid;
  logic       busy;

  // master: key source / round-key consumer
  modport master (
    output key_valid, key_in, rk_idx,
    input  key_ready, rk_out, keys_valid, busy
  );

  // slave: the key expander itself
  modport slave (
    input  key_valid, key_in, rk_idx,
    output key_ready, rk_out, keys_valid, busy
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (8-bit in, 8-bit out).
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Table lookup.
  always_comb begin
    dout = SBOX[din];
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: accepts a cipher key, derives round keys
// 1..10 at one per clock and serves all 11 keys through a registered read port.
module aes_key_expander
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  aes_key_expander_if.slave  bus
);

  fsm_t       state_q, state_d;
  logic [3:0] rnd_q;
  block_t     rk_q [AES_NR+1];
  block_t     rk_out_q;
  logic       keys_valid_q;

  logic       accept;
  logic       expand;
  logic       last;

  block_t     prev_key;
  block_t     next_key;
  block_t     rd_data;
  word_t      w0, w1, w2, w3;
  word_t      rot, sub, t;
  word_t      n0, n1, n2, n3;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    expand  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          accept  = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        expand = 1'b1;
        if (rnd_q == 4'(AES_NR)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the previous round key rk[rnd-1] as the schedule input.
  always_comb begin
    prev_key = '0;
    for (int unsigned i = 1; i <= AES_NR; i++) begin
      if (rnd_q == 4'(i)) prev_key = rk_q[i-1];
    end
  end

  assign {w0, w1, w2, w3} = prev_key;
  assign rot = rot_word(w3);

  aes_sbox u_sbox0 (.din(rot[31:24]), .dout(sub[31:24]));
  aes_sbox u_sbox1 (.din(rot[23:16]), .dout(sub[23:16]));
  aes_sbox u_sbox2 (.din(rot[15:8]),  .dout(sub[15:8]));
  aes_sbox u_sbox3 (.din(rot[7:0]),   .dout(sub[7:0]));

  // One round of the word recurrence: SubWord/RotWord/Rcon then XOR chain.
  always_comb begin
    t        = sub ^ {rcon_of(rnd_q), 24'h0};
    n0       = w0 ^ t;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Read mux; indices above 10 read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i <= AES_NR; i++) begin
      if (bus.rk_idx == 4'(i)) rd_data = rk_q[i];
    end
  end

  // Key storage, round counter, completion flag and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= AES_NR; i++) rk_q[i] <= '0;
      rnd_q        <= '0;
      keys_valid_q <= 1'b0;
      rk_out_q     <= '0;
    end else begin
      rk_out_q <= rd_data;
      if (accept) begin
        rk_q[0]      <= bus.key_in;
        rnd_q        <= 4'd1;
        keys_valid_q <= 1'b0;
      end else if (expand) begin
        for (int unsigned i = 1; i <= AES_NR; i++) begin
          if (rnd_q == 4'(i)) rk_q[i] <= next_key;
        end
        if (last) keys_valid_q <= 1'b1;
        else      rnd_q        <= rnd_q + 4'd1;
      end
    end
  end

  assign bus.key_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q == EXPAND);
  assign bus.keys_valid = keys_valid_q;
  assign bus.rk_out     = rk_out_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander with a GF(2^8)-based reference model.
module tb_aes_key_expander;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [127:0] exp_rk [11];

  localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expander_if bus ();

  aes_key_expander dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    if (b != 8'h00) begin
      for (int c = 1; c < 256; c++) begin
        if (gf_mul(b, 8'(c)) == 8'h01) inv = 8'(c);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_ref(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = gf_mul(rc, 8'h02);
    return rc;
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]), sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0])};
        tmp = tmp ^ {rcon_ref(i / 4), 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst_n         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.rk_idx    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Present a key for one edge; leaves key_valid high if hold is set.
  task automatic accept_key(input logic [127:0] key, input bit hold, input string name);
    bus.key_valid = 1'b1;
    bus.key_in    = key;
    @(posedge clk);
    #1;
    if (!hold) bus.key_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.key_ready !== 1'b0 || bus.keys_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: busy=%b key_ready=%b keys_valid=%b, expected 1 0 0",
               name, bus.busy, bus.key_ready, bus.keys_valid);
    end
  endtask

  task automatic wait_keys_valid(input string name);
    int cnt;
    cnt = 0;
    while (bus.keys_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_checks++;
    if (bus.keys_valid !== 1'b1 || cnt != 10) begin
      n_fail++;
      $display("FAIL %s_latency: keys_valid=%b after %0d cycles, expected 1 after 10",
               name, bus.keys_valid, cnt);
    end
    n_checks++;
    if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_flags: key_ready=%b busy=%b, expected 1 0", name, bus.key_ready, bus.busy);
    end
  endtask

  task automatic read_rk(input int idx, output logic [127:0] v);
    bus.rk_idx = 4'(idx);
    @(posedge clk);
    #1;
    v = bus.rk_out;
  endtask

  // Sweep rk_idx 0..15 on consecutive cycles against exp_rk (zero above 10).
  task automatic read_all(input string name);
    logic [127:0] expv;
    for (int i = 0; i < 16; i++) begin
      bus.rk_idx = 4'(i);
      @(posedge clk);
      #1;
      expv = (i <= 10) ? exp_rk[i] : 128'h0;
      n_checks++;
      if (bus.rk_out !== expv) begin
        n_fail++;
        $display("FAIL %s_rk%0d: got %h expected %h", name, i, bus.rk_out, expv);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.key_ready !== 1'b1 || bus.keys_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: key_ready=%b keys_valid=%b busy=%b, expected 1 0 0",
               bus.key_ready, bus.keys_valid, bus.busy);
    end
    for (int i = 0; i < 16; i++) exp_rk[i % 11] = '0;
    read_all("reset");
  endtask

  task automatic test_fips();
    logic [127:0] v;
    model_expand(FIPS_KEY);
    accept_key(FIPS_KEY, 1'b0, "fips");
    wait_keys_valid("fips");
    read_rk(1, v);
    n_checks++;
    if (v !== FIPS_RK1) begin
      n_fail++;
      $display("FAIL fips_rk1_vector: got %h expected %h", v, FIPS_RK1);
    end
    read_rk(10, v);
    n_checks++;
    if (v !== FIPS_RK10) begin
      n_fail++;
      $display("FAIL fips_rk10_vector: got %h expected %h", v, FIPS_RK10);
    end
    read_all("fips");
  endtask

  task automatic test_zero_key();
    logic [127:0] v;
    model_expand('0);
    accept_key('0, 1'b0, "zero");
    wait_keys_valid("zero");
    read_rk(1, v);
    n_checks++;
    if (v !== ZERO_RK1) begin
      n_fail++;
      $display("FAIL zero_rk1_vector: got %h expected %h", v, ZERO_RK1);
    end
    read_rk(10, v);
    n_checks++;
    if (v !== ZERO_RK10) begin
      n_fail++;
      $display("FAIL zero_rk10_vector: got %h expected %h", v, ZERO_RK10);
    end
    read_all("zero");
  endtask

  task automatic test_random_keys();
    logic [127:0] key;
    for (int k = 0; k < 4; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      model_expand(key);
      accept_key(key, 1'b0, "random");
      wait_keys_valid("random");
      read_all("random");
    end
  endtask

  task automatic test_back_to_back();
    // First key accepted, then zero key held valid throughout its expansion.
    accept_key(FIPS_KEY, 1'b1, "b2b_first");
    bus.key_in = '0;
    wait_keys_valid("b2b_first");
    // Read rk[10] in the cycle keys_valid first rises; zero key is accepted on this edge.
    bus.rk_idx = 4'd10;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    n_checks++;
    if (bus.rk_out !== FIPS_RK10) begin
      n_fail++;
      $display("FAIL b2b_final_read: got %h expected %h", bus.rk_out, FIPS_RK10);
    end
    n_checks++;
    if (bus.keys_valid !== 1'b0 || bus.busy !== 1'b1 || bus.key_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_accept: keys_valid=%b busy=%b key_ready=%b, expected 0 1 0",
               bus.keys_valid, bus.busy, bus.key_ready);
    end
    model_expand('0);
    wait_keys_valid("b2b_second");
    read_all("b2b_second");
  endtask

  task automatic test_reset_mid();
    logic [127:0] key;
    key = {$urandom, $urandom, $urandom, $urandom};
    bus.rk_idx = 4'd0;
    accept_key(key, 1'b0, "midrst");
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.key_ready !== 1'b1 || bus.keys_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rk_out !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: key_ready=%b keys_valid=%b busy=%b rk_out=%h, expected 1 0 0 0",
               bus.key_ready, bus.keys_valid, bus.busy, bus.rk_out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) exp_rk[i] = '0;
    read_all("midrst_cleared");
    model_expand(FIPS_KEY);
    accept_key(FIPS_KEY, 1'b0, "midrst_fresh");
    wait_keys_valid("midrst_fresh");
    read_all("midrst_fresh");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    test_reset();
    test_fips();
    test_zero_key();
    test_random_keys();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
